// File: rtl/uart_case_ctrl.sv
// uart_case_ctrl: sequencer between UART RX and UART TX for the case converter.
// Received bytes are queued in a small FIFO, case-converted according to mode
// when popped, and handed to the transmitter with a start/busy handshake.
// Optional feature macro: UART_CC_CRLF_EN (send 0x0A after every popped 0x0D).
module uart_case_ctrl #(
  parameter int FIFO_DEPTH  = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic [1:0]                    mode,
  input  logic                          tx_busy,
  output logic [7:0]                    tx_data,
  output logic                          tx_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          idle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

`ifdef UART_CC_CRLF_EN
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_LF_PEND   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3
  } state_t;
`endif

  // Case conversion of one byte; only the ASCII letter ranges are touched.
  function automatic logic [7:0] case_conv(input logic [7:0] b, input logic [1:0] m);
    logic       is_lower;
    logic       is_upper;
    logic [7:0] r;
    is_lower = (b >= 8'h61) && (b <= 8'h7A);
    is_upper = (b >= 8'h41) && (b <= 8'h5A);
    case (m)
      2'b00:   r = b;
      2'b01:   r = is_lower ? (b - 8'h20) : b;
      2'b10:   r = is_upper ? (b + 8'h20) : b;
      2'b11:   r = is_lower ? (b - 8'h20) : (is_upper ? (b + 8'h20) : b);
      default: r = b;
    endcase
    return r;
  endfunction

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [LW-1:0] level_nxt_s;
  logic          rx_prev_r;
  logic          overflow_r;
  logic [7:0]    tx_data_r;
  logic          tx_start_r;
  logic          idle_r;
  state_t        state_r;
  state_t        state_nxt_s;
  state_t        done_nxt_s;
  logic [TW-1:0] timer_r;
  logic [TW-1:0] timer_nxt_s;
  logic          push_s;
  logic          push_ok_s;
  logic          pop_s;
  logic          load_lf_s;
  logic          empty_s;
  logic          full_s;
  logic [7:0]    head_s;
  logic [7:0]    conv_s;
`ifdef UART_CC_CRLF_EN
  logic          cr_pend_r;
`endif

  assign push_s  = rx_valid & ~rx_prev_r;
  assign empty_s = (level_r == {LW{1'b0}});
  assign full_s  = (level_r == LW'(FIFO_DEPTH));
  assign head_s  = mem_r[rd_ptr_r];
  assign conv_s  = case_conv(head_s, mode);

  // Push acceptance and next occupancy; a pop frees room for a same-cycle push when full.
  always_comb begin
    push_ok_s = push_s & (~full_s | pop_s);
    if (push_ok_s && !pop_s) begin
      level_nxt_s = level_r + LW'(1);
    end else if (pop_s && !push_ok_s) begin
      level_nxt_s = level_r - LW'(1);
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Where a finished byte goes next: straight to IDLE, or via LF_PEND after a CR.
  always_comb begin
`ifdef UART_CC_CRLF_EN
    if (cr_pend_r) begin
      done_nxt_s = ST_LF_PEND;
    end else begin
      done_nxt_s = ST_IDLE;
    end
`else
    done_nxt_s = ST_IDLE;
`endif
  end

  // Handshake FSM next-state logic; pop only when TX is free and data is queued.
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    pop_s       = 1'b0;
    load_lf_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s && !tx_busy) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        timer_nxt_s = {TW{1'b0}};
        state_nxt_s = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (tx_busy) begin
          state_nxt_s = ST_WAIT_DONE;
        end else if (timer_r == TW'(ACK_TIMEOUT)) begin
          state_nxt_s = done_nxt_s;
        end else begin
          timer_nxt_s = timer_r + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt_s = done_nxt_s;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
`ifdef UART_CC_CRLF_EN
      ST_LF_PEND: begin
        if (!tx_busy) begin
          load_lf_s   = 1'b1;
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_LF_PEND;
        end
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FIFO storage; data words need no reset, occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= rx_data;
    end
  end

  // FIFO pointers, occupancy, rx_valid edge history and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= {LW{1'b0}};
      rx_prev_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      rx_prev_r <= rx_valid;
      level_r   <= level_nxt_s;
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (push_s && full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // FSM state, ack timer and the registered transmitter-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      timer_r    <= {TW{1'b0}};
      tx_data_r  <= 8'h00;
      tx_start_r <= 1'b0;
      idle_r     <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      timer_r    <= timer_nxt_s;
      tx_start_r <= (state_r == ST_START);
      idle_r     <= (level_nxt_s == {LW{1'b0}}) && (state_nxt_s == ST_IDLE);
      if (pop_s) begin
        tx_data_r <= conv_s;
      end else if (load_lf_s) begin
        tx_data_r <= 8'h0A;
      end
    end
  end

`ifdef UART_CC_CRLF_EN
  // Remembers that the byte in flight was a CR so an LF follows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_pend_r <= 1'b0;
    end else if (pop_s) begin
      cr_pend_r <= (conv_s == 8'h0D);
    end else if (load_lf_s) begin
      cr_pend_r <= 1'b0;
    end
  end
`endif

  assign tx_data    = tx_data_r;
  assign tx_start   = tx_start_r;
  assign fifo_level = level_r;
  assign overflow   = overflow_r;
  assign idle       = idle_r;

endmodule

// File: tb/tb_uart_case_ctrl.sv
// tb_uart_case_ctrl: directed self-checking bench for uart_case_ctrl with a
// small transmitter model that records every tx_start and its byte.
module tb_uart_case_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [1:0] mode;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [4:0] fifo_level;
  logic       overflow;
  logic       idle;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc      = 0;
  logic       hold_busy;
  logic       ack_en;
  int         busy_len;
  int         busy_cnt;
  logic [7:0] sent_q[$];
  int         start_q[$];

  uart_case_ctrl #(.FIFO_DEPTH(16), .ACK_TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .mode       (mode),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .idle       (idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmitter model: records each start, then holds busy for busy_len cycles if acking.
  initial begin
    tx_busy  = 1'b0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
        tx_busy  = 1'b0;
      end else begin
        if (tx_start) begin
          check_eq("start_while_busy", 32'(tx_busy), 32'd0);
          sent_q.push_back(tx_data);
          start_q.push_back(cyc);
          if (ack_en) busy_cnt = busy_len;
        end
        if (busy_cnt > 0) begin
          tx_busy  = 1'b1;
          busy_cnt = busy_cnt - 1;
        end else begin
          tx_busy = hold_busy;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_sent(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (sent_q.size() < n && k < budget) begin
      @(negedge clk);
      k = k + 1;
    end
    check_eq(tag, 32'(sent_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (!(idle && !tx_busy) && k < budget) begin
      @(negedge clk);
      k = k + 1;
    end
    check_eq(tag, 32'(idle && !tx_busy), 32'd1);
  endtask

  task automatic clear_log();
    sent_q.delete();
    start_q.delete();
  endtask

  initial begin
    logic [1:0] m_tab [10];
    logic [7:0] b_tab [10];
    logic [7:0] e_tab [10];
    int         n0;
    int         k;

    m_tab = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1};
    b_tab = '{8'h6D, 8'h51, 8'h7B, 8'h60, 8'h7A, 8'h40, 8'h5A, 8'h41, 8'h5B, 8'hE1};
    e_tab = '{8'h4D, 8'h71, 8'h7B, 8'h60, 8'h5A, 8'h40, 8'h7A, 8'h61, 8'h5B, 8'hE1};

    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    mode      = 2'b00;
    hold_busy = 1'b0;
    ack_en    = 1'b1;
    busy_len  = 10;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'h00);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_idle", 32'(idle), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Upper mode, latency of 3 clocks, held rx_valid pushes once, ordering
    clear_log();
    mode     = 2'b01;
    rx_data  = 8'h61;
    rx_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        check_eq("lat_level1", 32'(fifo_level), 32'd1);
        check_eq("lat_idle_low", 32'(idle), 32'd0);
      end
      check_eq($sformatf("lat_start_%0d", i), 32'(tx_start), 32'(i == 3));
    end
    check_eq("lat_tx_data", 32'(tx_data), 32'h41);
    rx_valid = 1'b0;
    push(8'h5A);
    push(8'h35);
    wait_sent(3, 500, "up3_sent_to");
    wait_idle(200, "up3_idle_to");
    check_eq("up3_count", 32'(sent_q.size()), 32'd3);
    check_eq("up3_b0", 32'(sent_q[0]), 32'h41);
    check_eq("up3_b1", 32'(sent_q[1]), 32'h5A);
    check_eq("up3_b2", 32'(sent_q[2]), 32'h35);
    check_eq("b2b_gap1", 32'(start_q[1] - start_q[0]), 32'd13);
    check_eq("b2b_gap2", 32'(start_q[2] - start_q[1]), 32'd13);
    check_eq("up3_level0", 32'(fifo_level), 32'd0);

    // Conversion table including range boundaries
    for (int i = 0; i < 10; i++) begin
      clear_log();
      mode = m_tab[i];
      push(b_tab[i]);
      wait_sent(1, 200, $sformatf("conv%0d_sent_to", i));
      check_eq($sformatf("conv%0d_m%0d_%0h", i, m_tab[i], b_tab[i]), 32'(sent_q[0]), 32'(e_tab[i]));
      wait_idle(200, $sformatf("conv%0d_idle_to", i));
    end

    // Ack timeout: TX never raises busy, the next byte still goes out
    clear_log();
    mode      = 2'b00;
    hold_busy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push(8'h78);
    push(8'h79);
    ack_en    = 1'b0;
    hold_busy = 1'b0;
    wait_sent(2, 300, "to_sent_to");
    check_eq("to_b0", 32'(sent_q[0]), 32'h78);
    check_eq("to_b1", 32'(sent_q[1]), 32'h79);
    check_eq("to_gap", 32'(start_q[1] - start_q[0]), 32'd18);
    wait_idle(200, "to_idle_to");
    ack_en = 1'b1;

    // Overflow: 17 bytes into a 16-deep FIFO while TX is held busy
    clear_log();
    hold_busy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) push(8'h30 + 8'(i));
    @(posedge clk); #1;
    check_eq("ovf_level", 32'(fifo_level), 32'd16);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ovf_idle", 32'(idle), 32'd0);
    hold_busy = 1'b0;
    wait_sent(16, 1000, "ovf_sent_to");
    wait_idle(200, "ovf_idle_to");
    repeat (5) @(negedge clk);
    check_eq("ovf_count", 32'(sent_q.size()), 32'd16);
    check_eq("ovf_first", 32'(sent_q[0]), 32'h30);
    check_eq("ovf_last", 32'(sent_q[15]), 32'h3F);
    check_eq("ovf_sticky", 32'(overflow), 32'd1);

    // CR handling
    clear_log();
    hold_busy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push(8'h0D);
    push(8'h6B);
    @(posedge clk); #1;
    check_eq("cr_level2", 32'(fifo_level), 32'd2);
    hold_busy = 1'b0;
`ifdef UART_CC_CRLF_EN
    wait_sent(3, 400, "cr_sent_to");
    wait_idle(200, "cr_idle_to");
    check_eq("cr_count", 32'(sent_q.size()), 32'd3);
    check_eq("cr_b0", 32'(sent_q[0]), 32'h0D);
    check_eq("cr_b1", 32'(sent_q[1]), 32'h0A);
    check_eq("cr_b2", 32'(sent_q[2]), 32'h6B);
`else
    wait_sent(2, 400, "cr_sent_to");
    wait_idle(200, "cr_idle_to");
    check_eq("cr_count", 32'(sent_q.size()), 32'd2);
    check_eq("cr_b0", 32'(sent_q[0]), 32'h0D);
    check_eq("cr_b1", 32'(sent_q[1]), 32'h6B);
`endif

    // Reset while waiting for the transmitter to finish
    clear_log();
    push(8'h72);
    k = 0;
    while (!tx_busy && k < 50) begin
      @(negedge clk);
      k = k + 1;
    end
    check_eq("mid_busy_seen", 32'(tx_busy), 32'd1);
    push(8'h73);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("mid_rst_tx_data", 32'(tx_data), 32'h00);
    check_eq("mid_rst_level", 32'(fifo_level), 32'd0);
    check_eq("mid_rst_overflow", 32'(overflow), 32'd0);
    check_eq("mid_rst_idle", 32'(idle), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = sent_q.size();
    repeat (30) @(negedge clk);
    check_eq("post_rst_no_start", 32'(sent_q.size()), 32'(n0));
    check_eq("post_rst_idle", 32'(idle), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
